// File: rtl/can_pkg.sv
// can_pkg - constants, types and helpers shared by the CAN/CAN FD CRC engine
// and the CRC field transmitter.
//  - CRC field lengths and generator polynomials (CRC15 / CRC17 / CRC21)
//  - MAX_LEN: longest transmitted CRC sequence (CRC21 + stuff count + 7 FSB)
//  - stuff_cnt_field(): gray-coded stuff count followed by its even parity bit
//  - crc_tx_state_t: CRC transmitter sequencer states
package can_pkg;

  localparam int CRC15_LEN = 15;
  localparam int CRC17_LEN = 17;
  localparam int CRC21_LEN = 21;

  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam logic [16:0] CRC17_POLY = 17'h1685B;
  localparam logic [20:0] CRC21_POLY = 21'h102899;

  // Stuff-count field: 3 gray bits + 1 parity bit.
  localparam int SC_LEN = 4;

  localparam int MAX_LEN = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } crc_tx_state_t;

  // Gray code of the stuff count, MSB first, followed by even parity over
  // the three gray bits.
  function automatic logic [3:0] stuff_cnt_field(input logic [2:0] cnt);
    logic [2:0] g;
    g = cnt ^ {1'b0, cnt[2:1]};
    return {g, ^g};
  endfunction

endpackage

// File: rtl/can_crc_fsb_pack.sv
// can_crc_fsb_pack - combinational builder of the CAN FD CRC sequence with
// fixed stuff bits (FSB).
//  An FSB (complement of the previous transmitted bit) precedes the first
//  field bit and follows every 4th field bit, except after the final one.
//  The first FSB is the complement of the bit driven before the CRC field.
// Ports
//  field      in   MAX_LEN  field bits, left-aligned (MSB transmitted first)
//  field_len  in   CW       number of valid field bits
//  last_bit   in   1        bit driven just before the CRC field
//  pattern    out  MAX_LEN  assembled sequence, left-aligned
//  len        out  CW       number of valid bits in pattern
module can_crc_fsb_pack #(
  parameter  int MAX_LEN = can_pkg::MAX_LEN,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] field,
  input  logic [CW-1:0]      field_len,
  input  logic               last_bit,
  output logic [MAX_LEN-1:0] pattern,
  output logic [CW-1:0]      len
);

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] MAXL = CW'(MAX_LEN);

  logic [MAX_LEN-1:0] fv;
  logic [MAX_LEN-1:0] acc;
  logic [CW-1:0]      rem;
  logic [CW-1:0]      n;
  logic [1:0]         grp;
  logic               b;

  // Bits are appended at the LSB end and the result is left-aligned at the end.
  always_comb begin
    fv  = field;
    rem = field_len;
    grp = 2'd0;
    b   = 1'b0;
    acc = {{(MAX_LEN-1){1'b0}}, ~last_bit};
    n   = ONE;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (rem != '0) begin
        b   = fv[MAX_LEN-1];
        fv  = {fv[MAX_LEN-2:0], 1'b0};
        acc = {acc[MAX_LEN-2:0], b};
        n   = n + ONE;
        rem = rem - ONE;
        grp = grp + 2'd1;
        // grp wraps to 0 after every 4th field bit
        if ((grp == 2'd0) && (rem != '0)) begin
          acc = {acc[MAX_LEN-2:0], ~b};
          n   = n + ONE;
        end
      end
    end
    pattern = acc << (MAXL - n);
    len     = n;
  end

endmodule

// File: rtl/can_crc_tx.sv
// can_crc_tx - transmit-side CRC field serializer for the CAN/CAN FD controller.
//  On start the CRC sequence is assembled (classic CRC15, or CAN FD CRC17/21
//  with optional ISO stuff-count field and fixed stuff bits) and then shifted
//  out MSB first, one bit per tx_point strobe.
//  Optional feature macro: CAN_CRC_TX_BITERR_EN (bus bit-error compare).
// Ports
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  tx_point      in   1   strobe: drive next bit
//  sample_point  in   1   strobe: bus sampled (bit-error compare only)
//  sampled_bit   in   1   bus value at sample_point
//  start         in   1   pulse: latch inputs, begin sequence
//  abort         in   1   stop immediately, no done pulse
//  fd            in   1   1 = CAN FD frame
//  fd_iso        in   1   1 = ISO FD (stuff-count field present)
//  crc_sel21     in   1   FD: 1 = CRC21, 0 = CRC17
//  crc_15/17/21  in   CRC register values
//  stuff_cnt     in   3   dynamic stuff bits sent so far, mod 8
//  last_bit      in   1   last bit driven before the CRC field
//  tx_bit        out  1   bit to transmit (recessive 1 when idle after reset/abort)
//  busy          out  1   sequence in progress
//  done          out  1   pulse after the last bit is driven
//  dyn_stuff_en  out  1   0 while an FD sequence is running
//  bit_err       out  1   pulse on bus mismatch (tied 0 without the macro)
module can_crc_tx #(
  parameter int MAX_LEN = can_pkg::MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_point,
  input  logic        sample_point,
  input  logic        sampled_bit,
  input  logic        start,
  input  logic        abort,
  input  logic        fd,
  input  logic        fd_iso,
  input  logic        crc_sel21,
  input  logic [14:0] crc_15,
  input  logic [16:0] crc_17,
  input  logic [20:0] crc_21,
  input  logic [2:0]  stuff_cnt,
  input  logic        last_bit,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic        dyn_stuff_en,
  output logic        bit_err
);

  import can_pkg::*;

  localparam int            CW  = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  crc_tx_state_t      state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q;
  logic [CW-1:0]      cnt_q;
  logic               tx_bit_q;
  logic               done_q;
  logic               fd_q;

  logic [MAX_LEN-1:0] field, pat_fd, pat_load;
  logic [CW-1:0]      field_len, len_fd, len_load;
  logic               load, shift, fin;

  // FD field selection (left-aligned), before FSB insertion
  always_comb begin
    field     = '0;
    field_len = '0;
    if (fd_iso) begin
      if (crc_sel21) begin
        field     = {stuff_cnt_field(stuff_cnt), crc_21, {(MAX_LEN-SC_LEN-CRC21_LEN){1'b0}}};
        field_len = CW'(SC_LEN + CRC21_LEN);
      end else begin
        field     = {stuff_cnt_field(stuff_cnt), crc_17, {(MAX_LEN-SC_LEN-CRC17_LEN){1'b0}}};
        field_len = CW'(SC_LEN + CRC17_LEN);
      end
    end else begin
      if (crc_sel21) begin
        field     = {crc_21, {(MAX_LEN-CRC21_LEN){1'b0}}};
        field_len = CW'(CRC21_LEN);
      end else begin
        field     = {crc_17, {(MAX_LEN-CRC17_LEN){1'b0}}};
        field_len = CW'(CRC17_LEN);
      end
    end
  end

  can_crc_fsb_pack #(.MAX_LEN(MAX_LEN)) u_fsb_pack (
    .field     (field),
    .field_len (field_len),
    .last_bit  (last_bit),
    .pattern   (pat_fd),
    .len       (len_fd)
  );

  assign pat_load = fd ? pat_fd : {crc_15, {(MAX_LEN-CRC15_LEN){1'b1}}};
  assign len_load = fd ? len_fd : CW'(CRC15_LEN);

  // Sequencer next state
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    fin     = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // tx_point coinciding with start is deliberately not acted on
          if (start) begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else if (tx_point) begin
            shift = 1'b1;
            if (cnt_q == ONE) begin
              fin     = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_bit_q <= 1'b1;
      done_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fin;
      if (abort) begin
        tx_bit_q <= 1'b1;
      end else if (shift) begin
        tx_bit_q <= shreg_q[MAX_LEN-1];
      end
      if (load) begin
        cnt_q <= len_load;
        fd_q  <= fd;
      end else if (shift) begin
        cnt_q <= cnt_q - ONE;
      end
    end
  end

  // Data shift register
  always_ff @(posedge clk) begin
    if (load) begin
      shreg_q <= pat_load;
    end else if (shift) begin
      shreg_q <= {shreg_q[MAX_LEN-2:0], 1'b1};
    end
  end

  assign tx_bit       = tx_bit_q;
  assign busy         = (state_q == SHIFT);
  assign done         = done_q;
  assign dyn_stuff_en = ~(busy & fd_q);

`ifdef CAN_CRC_TX_BITERR_EN
  logic cmp_q;
  logic bit_err_q;

  // Bus compare against the bit most recently driven
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q     <= 1'b1;
      bit_err_q <= 1'b0;
    end else begin
      if (shift) begin
        cmp_q <= shreg_q[MAX_LEN-1];
      end
      bit_err_q <= sample_point & busy & ~abort & (sampled_bit != cmp_q);
    end
  end

  assign bit_err = bit_err_q;
`else
  logic unused_biterr;
  assign unused_biterr = &{1'b0, sample_point, sampled_bit};
  assign bit_err       = 1'b0;
`endif

endmodule

// File: tb/tb_can_crc_tx.sv
module tb_can_crc_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_point, sample_point, sampled_bit, start, abort;
  logic        fd, fd_iso, crc_sel21, last_bit;
  logic [14:0] crc_15;
  logic [16:0] crc_17;
  logic [20:0] crc_21;
  logic [2:0]  stuff_cnt;
  logic        tx_bit, busy, done, dyn_stuff_en, bit_err;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic exp_q[$];
  logic last_tx;

`ifdef CAN_CRC_TX_BITERR_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  always #5 clk = ~clk;

  can_crc_tx dut (
    .clk          (clk),
    .rst          (rst),
    .tx_point     (tx_point),
    .sample_point (sample_point),
    .sampled_bit  (sampled_bit),
    .start        (start),
    .abort        (abort),
    .fd           (fd),
    .fd_iso       (fd_iso),
    .crc_sel21    (crc_sel21),
    .crc_15       (crc_15),
    .crc_17       (crc_17),
    .crc_21       (crc_21),
    .stuff_cnt    (stuff_cnt),
    .last_bit     (last_bit),
    .tx_bit       (tx_bit),
    .busy         (busy),
    .done         (done),
    .dyn_stuff_en (dyn_stuff_en),
    .bit_err      (bit_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference sequence built straight from the frame format description
  task automatic push_expected(input logic f, input logic iso, input logic s21,
                               input logic [14:0] c15, input logic [16:0] c17,
                               input logic [20:0] c21, input logic [2:0] sc,
                               input logic lb);
    logic       fq[$];
    logic [2:0] g;
    if (!f) begin
      for (int i = 14; i >= 0; i--) exp_q.push_back(c15[i]);
      return;
    end
    if (iso) begin
      g = sc ^ (sc >> 1);
      fq.push_back(g[2]);
      fq.push_back(g[1]);
      fq.push_back(g[0]);
      fq.push_back(^g);
    end
    if (s21) for (int i = 20; i >= 0; i--) fq.push_back(c21[i]);
    else     for (int i = 16; i >= 0; i--) fq.push_back(c17[i]);
    exp_q.push_back(~lb);
    for (int i = 0; i < fq.size(); i++) begin
      exp_q.push_back(fq[i]);
      if (((i + 1) % 4 == 0) && (i + 1 < fq.size())) exp_q.push_back(~fq[i]);
    end
  endtask

  // Runs one sequence; called at posedge+1. len is the frame length expected
  // from the frame type; abort_at < 0 runs to completion.
  task automatic run_frame(input logic f, input logic iso, input logic s21,
                           input logic [14:0] c15, input logic [16:0] c17,
                           input logic [20:0] c21, input logic [2:0] sc,
                           input logic lb, input int len, input int abort_at,
                           input bit inject);
    logic e;
    exp_q.delete();
    push_expected(f, iso, s21, c15, c17, c21, sc, lb);
    fd = f; fd_iso = iso; crc_sel21 = s21; crc_15 = c15; crc_17 = c17;
    crc_21 = c21; stuff_cnt = sc; last_bit = lb;
    start = 1'b1; tx_point = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tx_point = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("tx_hold_at_start", tx_bit, last_tx);
    chk("dyn_stuff_en_busy", dyn_stuff_en, !f);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_tx_bit", tx_bit, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_dyn_stuff_en", dyn_stuff_en, 1'b1);
        tx_point = 1'b1;
        @(posedge clk); #1;
        tx_point = 1'b0;
        chk("abort_no_shift", tx_bit, 1'b1);
        chk("abort_no_done", done, 1'b0);
        last_tx = 1'b1;
        exp_q.delete();
        return;
      end
      tx_point = 1'b1;
      @(posedge clk); #1;
      tx_point = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("tx_bit[%0d]", i), tx_bit, e);
      chk($sformatf("done[%0d]", i), done, (i == len - 1));
      chk($sformatf("busy[%0d]", i), busy, (i != len - 1));
      chk($sformatf("bit_err_idle[%0d]", i), bit_err, 1'b0);
      // gap cycle: bus sample, and a start that must be ignored while busy
      sample_point = 1'b1;
      sampled_bit  = tx_bit ^ (inject && (i == 3));
      start        = (i == 2);
      @(posedge clk); #1;
      sample_point = 1'b0;
      start        = 1'b0;
      chk($sformatf("bit_err[%0d]", i), bit_err,
          BE && inject && (i == 3) && (i != len - 1));
      last_tx = e;
    end
    chk("done_one_cycle", done, 1'b0);
    chk("tx_hold_end", tx_bit, last_tx);
    chk("busy_end", busy, 1'b0);
    chk("dyn_stuff_en_end", dyn_stuff_en, 1'b1);
  endtask

  function automatic int frame_len(input logic f, input logic iso, input logic s21);
    if (!f) return 15;
    if (iso) return s21 ? 32 : 27;
    return s21 ? 27 : 22;
  endfunction

  initial begin
    logic        rf, ri, rs;
    logic [20:0] r21;
    rst = 1'b1; tx_point = 1'b0; sample_point = 1'b0; sampled_bit = 1'b1;
    start = 1'b0; abort = 1'b0; fd = 1'b0; fd_iso = 1'b0; crc_sel21 = 1'b0;
    crc_15 = '0; crc_17 = '0; crc_21 = '0; stuff_cnt = '0; last_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_bit", tx_bit, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dyn_stuff_en", dyn_stuff_en, 1'b1);
    chk("rst_bit_err", bit_err, 1'b0);
    rst = 1'b0;
    last_tx = 1'b1;
    @(posedge clk); #1;

    // classic CRC15
    run_frame(1'b0, 1'b0, 1'b0, 15'h4A5B, '0, '0, 3'd0, 1'b0, 15, -1, 1'b0);
    // FD ISO CRC17 with bit-error injection on bit 3
    run_frame(1'b1, 1'b1, 1'b0, '0, 17'h1A5C3, '0, 3'd5, 1'b0, 27, -1, 1'b1);
    // FD ISO CRC21 all zero
    run_frame(1'b1, 1'b1, 1'b1, '0, '0, 21'h0, 3'd0, 1'b1, 32, -1, 1'b0);
    // FD non-ISO CRC17 all ones
    run_frame(1'b1, 1'b0, 1'b0, '0, 17'h1FFFF, '0, 3'd0, 1'b1, 22, -1, 1'b0);
    // FD non-ISO CRC21
    run_frame(1'b1, 1'b0, 1'b1, '0, '0, 21'h15A3C7, 3'd6, 1'b0, 27, -1, 1'b0);
    // abort at bit 10, then the same frame in full
    run_frame(1'b1, 1'b1, 1'b1, '0, '0, 21'h0B3E91, 3'd3, 1'b0, 32, 10, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, '0, '0, 21'h0B3E91, 3'd3, 1'b0, 32, -1, 1'b0);

    // asynchronous reset in the middle of a sequence
    fd = 1'b1; fd_iso = 1'b1; crc_sel21 = 1'b0; crc_17 = 17'h0F0F0;
    stuff_cnt = 3'd2; last_bit = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      tx_point = 1'b1;
      @(posedge clk); #1;
      tx_point = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midrst_tx_bit", tx_bit, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_dyn_stuff_en", dyn_stuff_en, 1'b1);
    chk("midrst_bit_err", bit_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_tx = 1'b1;
    @(posedge clk); #1;

    // a few random frames
    for (int k = 0; k < 4; k++) begin
      rf  = 1'($urandom_range(0, 1));
      ri  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      r21 = 21'($urandom);
      run_frame(rf, ri, rs, 15'($urandom), 17'($urandom), r21,
                3'($urandom), 1'($urandom), frame_len(rf, ri, rs), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
